dual_issue_pair_split: RTL

Dual-issue pairing stage between fetch and the dual ID/EX pipeline register. It accepts a fetched two-instruction bundle and checks intra-pair hazards. A legal bundle is forwarded as one pair. A conflicting bundle is split across two cycles, with a NOP (32'd0) in the empty slot. Its outputs drive the ID/EX register's `pc_in`, `decoded1` and `decoded2` directly.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/pair_hazard_check.sv | 72 +++++++
 rtl/dual_issue_pair_split.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants and pairing-stage types
//
// Purpose: opcode/funct encodings, the NOP word and the pairing FSM state
// type used by the dual-issue pairing stage and its hazard checker.
// Ports: none (package).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [4:0]  REG_RA  = 5'd31;
  localparam logic [31:0] NOP     = 32'd0;

  typedef enum logic {
    PASS  = 1'b0,
    SPLIT = 1'b1
  } pair_state_t;

endpackage

// File: rtl/pair_hazard_check.sv
// rtl/pair_hazard_check.sv - combinational intra-bundle hazard detector
//
// Purpose: decides whether two program-ordered instructions may issue
// together. Register 0 is encoded as "no register", so it never matches.
// Ports:
//   instr1, instr2  in  32  bundle, program order
//   conflict        out 1   bundle must be split
//   raw/waw/mem/ctl out 1   individual causes, for debug
module pair_hazard_check
  import mips_pkg::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic        conflict,
  output logic        raw,
  output logic        waw,
  output logic        mem,
  output logic        ctl
);

  function automatic logic [4:0] dest_of(input logic [31:0] instr);
    case (instr[31:26])
      OP_RTYPE:                          dest_of = instr[15:11];
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW:             dest_of = instr[20:16];
      OP_JAL:                            dest_of = REG_RA;
      default:                           dest_of = 5'd0;
    endcase
  endfunction

  // rs is read by everything except the absolute jumps.
  function automatic logic [4:0] src_rs(input logic [31:0] instr);
    if (instr[31:26] == OP_J || instr[31:26] == OP_JAL) src_rs = 5'd0;
    else                                                 src_rs = instr[25:21];
  endfunction

  // rt is a source only for R-type, stores and compare-branches.
  function automatic logic [4:0] src_rt(input logic [31:0] instr);
    case (instr[31:26])
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: src_rt = instr[20:16];
      default:                         src_rt = 5'd0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    is_mem = (op == OP_LW) || (op == OP_SW);
  endfunction

  logic [4:0] dst1;
  logic [4:0] dst2;
  logic [4:0] rs2;
  logic [4:0] rt2;
  logic [5:0] op1;
  logic       unused_bits;

  assign dst1 = dest_of(instr1);
  assign dst2 = dest_of(instr2);
  assign rs2  = src_rs(instr2);
  assign rt2  = src_rt(instr2);
  assign op1  = instr1[31:26];

  assign raw = (dst1 != 5'd0) && ((rs2 == dst1) || (rt2 == dst1));
  assign waw = (dst1 != 5'd0) && (dst1 == dst2);
  assign mem = is_mem(op1) && is_mem(instr2[31:26]);
  assign ctl = (op1 == OP_J) || (op1 == OP_JAL) || (op1 == OP_BEQ) || (op1 == OP_BNE) ||
               ((op1 == OP_RTYPE) && (instr1[5:0] == FN_JR));

  assign conflict = raw || waw || mem || ctl;

  assign unused_bits = ^{instr1[10:6], instr2[10:0]};

endmodule

// File: rtl/dual_issue_pair_split.sv
// rtl/dual_issue_pair_split.sv - dual-issue pairing stage with hazard split
//
// Purpose: forwards a fetched two-instruction bundle as one pair, or splits a
// conflicting bundle over two cycles (NOP in slot 2). Outputs feed the ID/EX
// register directly and are combinational from state, hold register and inputs.
// Ports:
//   clk, reset (async, active-low)
//   valid_in, pc_in, instr1_in, instr2_in   fetch bundle
//   stall, flush                            downstream freeze / redirect
//   in_ready                                bundle consumed this cycle
//   pc_out, decoded1, decoded2              slot PC and contents
//   split_count                             saturating count of split bundles
module dual_issue_pair_split
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr1_in,
  input  logic [31:0]      instr2_in,
  input  logic             stall,
  input  logic             flush,
  output logic             in_ready,
  output logic [31:0]      pc_out,
  output logic [31:0]      decoded1,
  output logic [31:0]      decoded2,
  output logic [CNT_W-1:0] split_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pair_state_t state;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic conflict;
  logic dbg_raw;
  logic dbg_waw;
  logic dbg_mem;
  logic dbg_ctl;
  logic unused_dbg;

  pair_hazard_check u_hazard (
    .instr1   (instr1_in),
    .instr2   (instr2_in),
    .conflict (conflict),
    .raw      (dbg_raw),
    .waw      (dbg_waw),
    .mem      (dbg_mem),
    .ctl      (dbg_ctl)
  );

  assign unused_dbg = ^{dbg_raw, dbg_waw, dbg_mem, dbg_ctl};

  // Flush outranks stall: it always returns to PASS and drops the held slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PASS;
      hold_instr  <= NOP;
      hold_pc     <= 32'd0;
      split_count <= '0;
    end else if (flush) begin
      state      <= PASS;
      hold_instr <= NOP;
    end else if (!stall) begin
      case (state)
        PASS: begin
          if (valid_in && conflict) begin
            state      <= SPLIT;
            hold_instr <= instr2_in;
            hold_pc    <= pc_in + 32'd4;
            if (split_count != '1) begin
              split_count <= split_count + CNT_ONE;
            end
          end
        end
        SPLIT: begin
          state <= PASS;
        end
        default: begin
          state <= PASS;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    pc_out   = 32'd0;
    decoded1 = NOP;
    decoded2 = NOP;
    if (state == SPLIT) begin
      decoded1 = hold_instr;
      pc_out   = hold_pc;
    end else begin
      in_ready = !stall && !flush;
      if (valid_in) begin
        decoded1 = instr1_in;
        decoded2 = conflict ? NOP : instr2_in;
        pc_out   = pc_in;
      end
    end
  end

endmodule
